// File: rtl/sy_pkg.sv
// Shared types and constants for the sy_* memory arbitration blocks.
package sy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sy_mem_arb_state_e;

  // Upper bound on memory read latency; the latency counter is sized from it.
  localparam int SY_MEM_ARB_MAX_LAT = 8;
  localparam int SY_MEM_ARB_CNT_W   = $clog2(SY_MEM_ARB_MAX_LAT);

endpackage

// File: rtl/sy_mem_arb_if.sv
// Requester-side valid/ready channels, memory macro port and status of sy_mem_arb.
interface sy_mem_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  localparam int GRANT_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0]            req_we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [NUM_REQ-1:0]            rsp_ready_i;
  logic [DATA_WIDTH-1:0]         rsp_rdata_o;
  logic                          mem_en_o;
  logic                          mem_we_o;
  logic [ADDR_WIDTH-1:0]         mem_addr_o;
  logic [DATA_WIDTH-1:0]         mem_wdata_o;
  logic [DATA_WIDTH-1:0]         mem_rdata_i;
  logic                          busy_o;
  logic [GRANT_W-1:0]            grant_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_wdata_o, busy_o, grant_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_wdata_o, busy_o, grant_o
  );
endinterface

// File: rtl/sy_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module sy_rr_pick #(
  parameter  int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any_valid
);

  logic [W:0] idx;

  // Scan from the farthest offset down so the closest-to-ptr hit wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (W + 1)'(i);
      if (idx >= (W + 1)'(N)) idx = idx - (W + 1)'(N);
      if (req[idx[W-1:0]]) begin
        grant     = idx[W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sy_mem_arb.sv
// Round-robin arbiter sharing one fixed-latency single-port memory among NUM_REQ requesters.
module sy_mem_arb
  import sy_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_LAT    = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  sy_mem_arb_if.slave  bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = SY_MEM_ARB_CNT_W;

  sy_mem_arb_state_e state, state_next;

  logic [GW-1:0]         ptr;
  logic [GW-1:0]         owner;
  logic [GW-1:0]         pick;
  logic                  any_valid;
  logic [CW-1:0]         cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = bus.req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  sy_rr_pick #(.N(NUM_REQ)) u_pick (
    .req       (bus.req_valid_i),
    .ptr       (ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Request accept is combinational in IDLE; the response stays up until its owner takes it.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready[pick] = 1'b1;
          state_next      = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (bus.rsp_ready_i[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner     <= pick;
            lat_we    <= bus.req_we_i[pick];
            lat_addr  <= addr_arr[pick];
            lat_wdata <= wdata_arr[pick];
          end
        end
        ISSUE: cnt <= CW'(MEM_LAT - 1);
        WAIT: begin
          // Writes still answer, with zero data, so every request gets one response.
          if (cnt == '0) rsp_data <= lat_we ? '0 : bus.mem_rdata_i;
          else           cnt      <= cnt - 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready_i[owner])
            ptr <= (owner == GW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_data;
  assign bus.mem_en_o    = (state == ISSUE);
  assign bus.mem_we_o    = lat_we;
  assign bus.mem_addr_o  = lat_addr;
  assign bus.mem_wdata_o = lat_wdata;
  assign bus.busy_o      = (state != IDLE);
  assign bus.grant_o     = (state == IDLE) ? '0 : owner;

endmodule

// File: tb/tb_sy_mem_arb.sv
// Directed self-checking bench for sy_mem_arb: one instance at MEM_LAT=1, one at MEM_LAT=4.
module tb_sy_mem_arb;

  localparam logic [63:0] KEY     = 64'hDEADBEEF_00010013;
  localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_evaluated = 0;
  int   n_failures  = 0;

  logic [63:0] pipe_a;
  logic [63:0] pipe_b [4];

  always #5 clk = ~clk;

  sy_mem_arb_if #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus_a ();
  sy_mem_arb_if #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus_b ();

  sy_mem_arb #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LAT(1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  sy_mem_arb #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LAT(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  // Memory models: read data is addr^KEY exactly MEM_LAT cycles after the strobe,
  // all-ones for writes, and a garbage pattern in every other cycle.
  always @(posedge clk) begin
    if (bus_a.mem_en_o) pipe_a <= bus_a.mem_we_o ? '1 : (bus_a.mem_addr_o ^ KEY);
    else                pipe_a <= GARBAGE;
    if (bus_b.mem_en_o) pipe_b[0] <= bus_b.mem_we_o ? '1 : (bus_b.mem_addr_o ^ KEY);
    else                pipe_b[0] <= GARBAGE;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end

  assign bus_a.mem_rdata_i = pipe_a;
  assign bus_b.mem_rdata_i = pipe_b[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                               input logic [63:0] addr0, input logic [63:0] addr1,
                               input logic [63:0] wdata0, input logic [63:0] wdata1,
                               input logic [1:0] rsp_ready);
    bus_a.req_valid_i = valid;
    bus_a.req_we_i    = we;
    bus_a.req_addr_i  = {addr1, addr0};
    bus_a.req_wdata_i = {wdata1, wdata0};
    bus_a.rsp_ready_i = rsp_ready;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_evaluated++;
    assert (observed === expected)
    else begin
      n_failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    bus_b.req_valid_i = '0;
    bus_b.req_we_i    = '0;
    bus_b.req_addr_i  = '0;
    bus_b.req_wdata_i = '0;
    bus_b.rsp_ready_i = '0;
    pipe_b[0] = GARBAGE; pipe_b[1] = GARBAGE; pipe_b[2] = GARBAGE; pipe_b[3] = GARBAGE;
    pipe_a = GARBAGE;
    tick(); tick(); tick();
    rst = 1'b0;
    settle();
    checkOutput("rst_busy",      bus_a.busy_o, 0);
    checkOutput("rst_mem_en",    bus_a.mem_en_o, 0);
    checkOutput("rst_mem_addr",  bus_a.mem_addr_o, 0);
    checkOutput("rst_req_ready", bus_a.req_ready_o, 0);
    checkOutput("rst_rsp_valid", bus_a.rsp_valid_o, 0);
    checkOutput("rst_grant",     bus_a.grant_o, 0);
    checkOutput("rst_rdata",     bus_a.rsp_rdata_o, 0);
    checkOutput("rst_b_busy",    bus_b.busy_o, 0);

    // Single read from requester 0
    tick();
    applyStimulus(2'b01, 2'b00, 64'h10000, '0, '0, '0, 2'b00);
    settle();
    checkOutput("rd_req_ready", bus_a.req_ready_o, 2'b01);
    checkOutput("rd_idle_busy", bus_a.busy_o, 0);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    settle();
    checkOutput("rd_mem_en",    bus_a.mem_en_o, 1);
    checkOutput("rd_mem_addr",  bus_a.mem_addr_o, 64'h10000);
    checkOutput("rd_mem_we",    bus_a.mem_we_o, 0);
    checkOutput("rd_grant",     bus_a.grant_o, 0);
    checkOutput("rd_busy",      bus_a.busy_o, 1);
    checkOutput("rd_no_ready",  bus_a.req_ready_o, 0);
    tick();
    settle();
    checkOutput("rd_en_pulse",  bus_a.mem_en_o, 0);
    checkOutput("rd_early_rsp", bus_a.rsp_valid_o, 0);
    tick();
    settle();
    checkOutput("rd_rsp_valid", bus_a.rsp_valid_o, 2'b01);
    checkOutput("rd_rsp_rdata", bus_a.rsp_rdata_o, 64'hDEADBEEF_00000013);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b01);
    tick();
    applyStimulus(2'b11, 2'b00, 64'h100, 64'h200, '0, '0, 2'b00);
    settle();
    checkOutput("rd_done_busy", bus_a.busy_o, 0);
    checkOutput("rd_done_rsp",  bus_a.rsp_valid_o, 0);
    checkOutput("ptr_adv_pick", bus_a.req_ready_o, 2'b10);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    settle();
    checkOutput("r1_grant",     bus_a.grant_o, 1);
    checkOutput("r1_mem_addr",  bus_a.mem_addr_o, 64'h200);
    tick(); tick();
    settle();
    checkOutput("r1_rsp_valid", bus_a.rsp_valid_o, 2'b10);
    checkOutput("r1_rsp_rdata", bus_a.rsp_rdata_o, 64'h200 ^ KEY);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b10);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);

    // Contention from a fresh pointer: grants alternate 0,1,0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00, 64'h100, 64'h200, '0, '0, 2'b11);
    for (int k = 0; k < 6; k++) begin
      settle();
      checkOutput($sformatf("cont_ready_%0d", k), bus_a.req_ready_o,
                  (k % 2 == 0) ? 64'd1 : 64'd2);
      tick(); tick(); tick();
      settle();
      checkOutput($sformatf("cont_rsp_%0d", k), bus_a.rsp_valid_o,
                  (k % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput($sformatf("cont_data_%0d", k), bus_a.rsp_rdata_o,
                  ((k % 2 == 0) ? 64'h100 : 64'h200) ^ KEY);
      tick();
    end
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);

    // Response backpressure on requester 0 while requester 1 waits
    tick();
    applyStimulus(2'b01, 2'b00, 64'h300, 64'h200, '0, '0, 2'b00);
    settle();
    checkOutput("bp_req_ready", bus_a.req_ready_o, 2'b01);
    tick();
    applyStimulus(2'b10, 2'b00, 64'h300, 64'h200, '0, '0, 2'b10);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      checkOutput($sformatf("bp_rsp_%0d", k),    bus_a.rsp_valid_o, 2'b01);
      checkOutput($sformatf("bp_data_%0d", k),   bus_a.rsp_rdata_o, 64'h300 ^ KEY);
      checkOutput($sformatf("bp_ready_%0d", k),  bus_a.req_ready_o, 0);
      checkOutput($sformatf("bp_mem_en_%0d", k), bus_a.mem_en_o, 0);
      tick();
    end
    applyStimulus(2'b10, 2'b10, 64'h300, 64'h20, '0, 64'hA5A5, 2'b01);
    settle();
    checkOutput("bp_still_held", bus_a.rsp_valid_o, 2'b01);

    // Write from requester 1 answers with zero data
    tick();
    applyStimulus(2'b10, 2'b10, '0, 64'h20, '0, 64'hA5A5, 2'b00);
    settle();
    checkOutput("wr_req_ready", bus_a.req_ready_o, 2'b10);
    checkOutput("wr_idle_rsp",  bus_a.rsp_valid_o, 0);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);
    settle();
    checkOutput("wr_mem_en",    bus_a.mem_en_o, 1);
    checkOutput("wr_mem_we",    bus_a.mem_we_o, 1);
    checkOutput("wr_mem_addr",  bus_a.mem_addr_o, 64'h20);
    checkOutput("wr_mem_wdata", bus_a.mem_wdata_o, 64'hA5A5);
    checkOutput("wr_grant",     bus_a.grant_o, 1);
    tick();
    settle();
    checkOutput("wr_en_pulse",  bus_a.mem_en_o, 0);
    checkOutput("wr_addr_hold", bus_a.mem_addr_o, 64'h20);
    tick();
    settle();
    checkOutput("wr_rsp_valid", bus_a.rsp_valid_o, 2'b10);
    checkOutput("wr_rsp_rdata", bus_a.rsp_rdata_o, 0);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b10);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);

    // Reset while waiting on memory drops the transaction
    tick();
    applyStimulus(2'b01, 2'b00, 64'h400, '0, 64'h77, '0, 2'b00);
    settle();
    checkOutput("mr_req_ready", bus_a.req_ready_o, 2'b01);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b01);
    settle();
    checkOutput("mr_wdata_lat", bus_a.mem_wdata_o, 64'h77);
    tick();
    rst = 1'b1;
    settle();
    checkOutput("mr_in_wait",   bus_a.busy_o, 1);
    tick();
    rst = 1'b0;
    settle();
    checkOutput("mr_busy",      bus_a.busy_o, 0);
    checkOutput("mr_mem_en",    bus_a.mem_en_o, 0);
    checkOutput("mr_mem_addr",  bus_a.mem_addr_o, 0);
    checkOutput("mr_mem_wdata", bus_a.mem_wdata_o, 0);
    checkOutput("mr_grant",     bus_a.grant_o, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      checkOutput($sformatf("mr_no_rsp_%0d", k), bus_a.rsp_valid_o, 0);
    end
    applyStimulus(2'b10, 2'b00, '0, 64'h500, '0, '0, 2'b10);
    settle();
    checkOutput("mr_fresh_ready", bus_a.req_ready_o, 2'b10);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b10);
    tick(); tick();
    settle();
    checkOutput("mr_fresh_rsp",  bus_a.rsp_valid_o, 2'b10);
    checkOutput("mr_fresh_data", bus_a.rsp_rdata_o, 64'h500 ^ KEY);
    tick();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b00);

    // Four-cycle memory latency on the second instance
    bus_b.req_valid_i = 2'b01;
    bus_b.req_addr_i  = {64'h0, 64'h10000};
    settle();
    checkOutput("l4_req_ready", bus_b.req_ready_o, 2'b01);
    tick();
    bus_b.req_valid_i = 2'b00;
    settle();
    checkOutput("l4_mem_en",    bus_b.mem_en_o, 1);
    checkOutput("l4_mem_addr",  bus_b.mem_addr_o, 64'h10000);
    for (int k = 2; k <= 5; k++) begin
      tick();
      settle();
      checkOutput($sformatf("l4_wait_rsp_T%0d", k), bus_b.rsp_valid_o, 0);
      checkOutput($sformatf("l4_wait_en_T%0d", k),  bus_b.mem_en_o, 0);
    end
    tick();
    settle();
    checkOutput("l4_rsp_valid", bus_b.rsp_valid_o, 2'b01);
    checkOutput("l4_rsp_rdata", bus_b.rsp_rdata_o, 64'hDEADBEEF_00000013);
    bus_b.rsp_ready_i = 2'b01;
    tick();
    bus_b.rsp_ready_i = 2'b00;
    settle();
    checkOutput("l4_done_busy", bus_b.busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_evaluated, n_failures);
    $finish;
  end

endmodule

// File: doc/sy_mem_arb.md
Name: sy_mem_arb

Overview:
- Round-robin arbiter and sequencer that shares one single-port memory-style macro (en/we/addr/wdata/rdata, fixed read latency) between NUM_REQ requesters. Typical macros: bootrom, scratch SRAM.
- Each requester side uses valid/ready request and response channels. The memory side matches the en/addr/we/wdata/rdata port of the TL-to-memory bridges, so an arbiter can sit between several bridges and one ROM/RAM instance.
- One transaction is in flight at a time. The response is held until the requester accepts it.

Parameters:
- NUM_REQ, 2, number of requesters, legal range 2..8.
- ADDR_WIDTH, 64, request/memory address width.
- DATA_WIDTH, 64, write/read data width.
- MEM_LAT, 1, cycles from mem_en_o high to mem_rdata_i valid, legal range 1..8.

Ports:
- clk_i  in  1  clock; the block has one clock.
- rst_i  in  1  reset, synchronous and active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accept; at most one bit high.
- req_we_i  in  NUM_REQ  per-requester write enable.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid_o  out  NUM_REQ  per-requester response valid; at most one bit high.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rsp_rdata_o  out  DATA_WIDTH  shared response data, qualified by rsp_valid_o.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- busy_o  out  1  high in every state except IDLE.
- grant_o  out  $clog2(NUM_REQ)  index of the current owner; 0 in IDLE.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state goes to IDLE and the RR pointer goes to 0.
  - All outputs are 0.
  - Any in-flight transaction is dropped and no response is produced.
  - The memory may still return data after reset; it is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick g = the first index with req_valid_i set, scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
  - If any valid is set: req_ready_o[g]=1 combinationally in that cycle (handshake completes), latch we/addr/wdata of g and g itself, go to ISSUE.
  - If no valid is set: remain in IDLE. req_ready_o is never high outside IDLE.
- ISSUE:
  - Drive mem_en_o=1 for exactly one cycle, with the latched mem_we_o/mem_addr_o/mem_wdata_o. These are registered, not combinational from req_*.
  - Load the latency counter with MEM_LAT-1, go to WAIT.
- WAIT:
  - If the counter is 0: capture mem_rdata_i into the response register on reads, or capture 0 on writes; go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid_o[g]=1 and rsp_rdata_o = captured data, both stable until rsp_ready_i[g].
  - On rsp_ready_i[g]: ptr=(g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready_i bits of other requesters are ignored.
- Latency: handshake at cycle T; mem_en_o at T+1; rdata sampled at T+MEM_LAT+1; rsp_valid_o from T+MEM_LAT+2.
  - Minimum turnaround is MEM_LAT+3 cycles per transaction, because the IDLE re-arbitration cycle is required.
- Writes produce a response with rdata=0 so every requester sees exactly one response per request.
- mem_addr_o/mem_we_o/mem_wdata_o hold their last values outside ISSUE. Consumers must qualify them with mem_en_o.
- Simultaneous requests: exactly one is granted. A requester that was not granted keeps valid asserted and must not change its fields (valid/ready rule); the block does not latch them.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.
- Illegal input: a requester dropping valid without a handshake is legal and simply not granted.

Decomposition:
- sy_pkg gets the state enum sy_mem_arb_state_e {IDLE, ISSUE, WAIT, RESP}.
- sy_pkg gets the constant SY_MEM_ARB_MAX_LAT=8, used to size the counter.
- Sub-module sy_rr_pick: a purely combinational round-robin picker. Inputs: req vector, ptr. Outputs: grant index, any_valid. It is reusable by other arbiters in sy_*.

Test Plan:
- Single read, MEM_LAT=1: req0 addr 0x10000 at T, memory model returns 0xDEADBEEF_00000013 → mem_en_o at T+1 with addr 0x10000, rsp_valid_o=01 at T+3 with that data, ptr becomes 1.
- Contention: req0 and req1 valid at the same T with reset ptr=0 → req0 granted first, req1 granted at the next IDLE. Six back-to-back requests alternate 0,1,0,1,0,1.
- Response backpressure: hold rsp_ready_i[0]=0 for 5 cycles → rsp_valid_o and rsp_rdata_o stable; req_ready_o stays 0; mem_en_o stays 0.
- Write: req1 we=1, addr 0x20, wdata 0xA5A5 → mem_en_o=mem_we_o=1 for one cycle with those values; rsp_valid_o=10 with rdata=0.
- MEM_LAT=4: read → rdata sampled 4 cycles after mem_en_o, rsp_valid_o at T+6; a wrong-cycle data pulse on mem_rdata_i is not captured.
- Reset mid-operation: assert rst_i while in WAIT → next cycle all outputs are 0 and state is IDLE; no response appears for the dropped request; a fresh request then completes normally.
